// File: rtl/free_list_mw.sv
// Multi-width free list of physical register indices with a speculative and a retire head.
// Define FREE_LIST_CHECK_EN to build the sticky protocol checker behind fl_err.
module free_list_mw #(
    parameter int PRF_DEPTH   = 64,
    parameter int ARF_DEPTH   = 32,
    parameter int ALLOC_WIDTH = 2,
    parameter int FREE_WIDTH  = 2,
    localparam int PRF_IDX    = $clog2(PRF_DEPTH),
    localparam int FL_DEPTH   = PRF_DEPTH - ARF_DEPTH,
    localparam int PTR_W      = $clog2(FL_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ALLOC_WIDTH-1:0]         alloc_valid,
    output logic                           alloc_ready,
    output logic [ALLOC_WIDTH*PRF_IDX-1:0] alloc_idx,
    input  logic [FREE_WIDTH-1:0]          free_valid,
    input  logic [FREE_WIDTH*PRF_IDX-1:0]  free_idx,
    input  logic                           flush,
    output logic [PTR_W-1:0]               count,
    output logic                           fl_err
);

    localparam int IDX_W = PTR_W - 1;

    logic [PRF_IDX-1:0] mem_q [FL_DEPTH];
    logic [PTR_W-1:0]   head_spec_q, head_spec_d;
    logic [PTR_W-1:0]   head_ret_q, head_ret_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [PTR_W-1:0]   n_a, n_f;
    logic [IDX_W-1:0]   a_off [ALLOC_WIDTH];
    logic [IDX_W-1:0]   f_off [FREE_WIDTH];
    logic [IDX_W-1:0]   a_addr [ALLOC_WIDTH];
    logic [IDX_W-1:0]   f_addr [FREE_WIDTH];
    logic               grant;

    // Prefix counts compact the set lanes onto consecutive slots.
    always_comb begin
        n_a = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            a_off[i] = IDX_W'(n_a);
            n_a      = n_a + {{(PTR_W-1){1'b0}}, alloc_valid[i]};
        end
    end

    always_comb begin
        n_f = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            f_off[i] = IDX_W'(n_f);
            n_f      = n_f + {{(PTR_W-1){1'b0}}, free_valid[i]};
        end
    end

    assign count       = tail_q - head_spec_q;
    assign alloc_ready = (count >= n_a) && !flush;
    assign grant       = alloc_ready && (n_a != '0);

    for (genvar i = 0; i < ALLOC_WIDTH; i++) begin : g_alloc
        assign a_addr[i] = head_spec_q[IDX_W-1:0] + a_off[i];
        assign alloc_idx[i*PRF_IDX +: PRF_IDX] =
            (alloc_valid[i] && alloc_ready) ? mem_q[a_addr[i]] : '0;
    end

    for (genvar i = 0; i < FREE_WIDTH; i++) begin : g_free
        assign f_addr[i] = tail_q[IDX_W-1:0] + f_off[i];
    end

    always_comb begin
        head_ret_d  = head_ret_q + n_f;
        tail_d      = tail_q + n_f;
        head_spec_d = head_spec_q;
        if (flush) begin
            head_spec_d = head_ret_q + n_f;
        end else if (grant) begin
            head_spec_d = head_spec_q + n_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                mem_q[k] <= PRF_IDX'(ARF_DEPTH + k);
            end
            head_spec_q <= '0;
            head_ret_q  <= '0;
            tail_q      <= PTR_W'(FL_DEPTH);
        end else begin
            for (int i = 0; i < FREE_WIDTH; i++) begin
                if (free_valid[i]) begin
                    mem_q[f_addr[i]] <= free_idx[i*PRF_IDX +: PRF_IDX];
                end
            end
            head_spec_q <= head_spec_d;
            head_ret_q  <= head_ret_d;
            tail_q      <= tail_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic              err_q, err_d;
    logic              chk_overflow, chk_pass, chk_low_idx;
    logic [PTR_W:0]    inflight_w;

    // Entries still owed a retirement, including this cycle's grant.
    assign inflight_w   = {1'b0, head_spec_q - head_ret_q} + (grant ? {1'b0, n_a} : '0);
    assign chk_overflow = ({1'b0, count} + {1'b0, n_f}) > (PTR_W+1)'(FL_DEPTH);
    assign chk_pass     = {1'b0, n_f} > inflight_w;

    always_comb begin
        chk_low_idx = 1'b0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            if (free_valid[i] && (free_idx[i*PRF_IDX +: PRF_IDX] < PRF_IDX'(ARF_DEPTH))) begin
                chk_low_idx = 1'b1;
            end
        end
    end

    assign err_d = err_q | chk_overflow | chk_pass | chk_low_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fl_err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!chk_overflow) else $error("free_list_mw: free overflows the list");
            assert (!chk_pass) else $error("free_list_mw: retire head passes speculative head");
            assert (!chk_low_idx) else $error("free_list_mw: freed index is architectural");
        end
    end
`endif
`else
    assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mw.sv
// Randomized bench for free_list_mw against a queue-based model of free and in-flight indices.
module tb_free_list_mw;

  localparam int PRF = 64;
  localparam int ARF = 32;
  localparam int AW = 2;
  localparam int FW = 2;
  localparam int PIDX = 6;
  localparam int FL = 32;
  localparam int PTR_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] alloc_valid;
  logic alloc_ready;
  logic [AW*PIDX-1:0] alloc_idx;
  logic [FW-1:0] free_valid;
  logic [FW*PIDX-1:0] free_idx;
  logic flush;
  logic [PTR_W-1:0] count;
  logic fl_err;

  free_list_mw #(
    .PRF_DEPTH(PRF), .ARF_DEPTH(ARF), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx), .flush(flush),
    .count(count), .fl_err(fl_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // avail: indices the speculative head will hand out, in order.
  // inflight: granted indices not yet retired, oldest first.
  logic [PIDX-1:0] avail[$];
  logic [PIDX-1:0] inflight[$];
  bit err_m;

  logic obs_ready;
  logic [PIDX-1:0] obs_lane0, obs_lane1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcnt2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic model_reset();
    avail.delete();
    inflight.delete();
    for (int k = 0; k < FL; k++) avail.push_back(PIDX'(ARF + k));
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alloc_valid = '0;
    free_valid = '0;
    free_idx = '0;
    flush = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_count", 32'(count), 32'(FL));
    check("reset_ready", 32'(alloc_ready), 32'd1);
    check("reset_err", 32'(fl_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive just after the edge, compare at negedge, then advance the model.
  task automatic drive_cycle(input logic [1:0] av, input logic [1:0] fv,
                             input logic [PIDX-1:0] f0, input logic [PIDX-1:0] f1,
                             input logic fl);
    int na, nf, j, granted;
    logic exp_ready;
    logic [PIDX-1:0] lane, fr[2];
    bit bad_idx;
    alloc_valid = av;
    free_valid = fv;
    free_idx = {f1, f0};
    flush = fl;
    @(negedge clk);
    na = popcnt2(av);
    nf = popcnt2(fv);
    exp_ready = (avail.size() >= na) && !fl;
    obs_ready = alloc_ready;
    obs_lane0 = alloc_idx[0 +: PIDX];
    obs_lane1 = alloc_idx[PIDX +: PIDX];
    check("count", 32'(count), 32'(avail.size()));
    check("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    check("fl_err", 32'(fl_err), 32'(err_m));
    j = 0;
    for (int i = 0; i < AW; i++) begin
      lane = alloc_idx[i*PIDX +: PIDX];
      if (av[i]) begin
        if (exp_ready) check($sformatf("alloc_idx%0d", i), 32'(lane), 32'(avail[j]));
        j++;
      end else begin
        check($sformatf("idle_lane%0d", i), 32'(lane), 32'd0);
      end
    end
    granted = (exp_ready && na > 0) ? na : 0;
    fr[0] = f0;
    fr[1] = f1;
    bad_idx = (fv[0] && f0 < ARF) || (fv[1] && f1 < ARF);
`ifdef FREE_LIST_CHECK_EN
    if ((avail.size() + nf > FL) || (nf > inflight.size() + granted) || bad_idx) err_m = 1'b1;
`else
    if (bad_idx) err_m = 1'b0;
`endif
    for (int g = 0; g < granted; g++) inflight.push_back(avail.pop_front());
    for (int r = 0; r < nf; r++) if (inflight.size() > 0) void'(inflight.pop_front());
    if (fl) begin
      for (int k = inflight.size() - 1; k >= 0; k--) avail.push_front(inflight[k]);
      inflight.delete();
    end
    for (int i = 0; i < FW; i++) if (fv[i]) avail.push_back(fr[i]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] av, fv;
    int room;
    rst_n = 1'b0;
    alloc_valid = '0;
    free_valid = '0;
    free_idx = '0;
    flush = 1'b0;
    model_reset();

    // Two-lane grant from reset.
    do_reset();
    drive_cycle(2'b11, 2'b00, 0, 0, 1'b0);
    check("t1_ready", 32'(obs_ready), 32'd1);
    check("t1_lane0", 32'(obs_lane0), 32'd32);
    check("t1_lane1", 32'(obs_lane1), 32'd33);
    check("t1_count", 32'(count), 32'd30);

    // Sparse lane request.
    do_reset();
    drive_cycle(2'b10, 2'b00, 0, 0, 1'b0);
    check("t3_lane1", 32'(obs_lane1), 32'd32);
    check("t3_lane0", 32'(obs_lane0), 32'd0);
    check("t3_count", 32'(count), 32'd31);

    // Drain to empty, then refill by one.
    do_reset();
    for (int c = 0; c < 16; c++) drive_cycle(2'b11, 2'b00, 0, 0, 1'b0);
    drive_cycle(2'b01, 2'b00, 0, 0, 1'b0);
    check("t2_empty_ready", 32'(obs_ready), 32'd0);
    check("t2_empty_count", 32'(count), 32'd0);
    drive_cycle(2'b00, 2'b01, 6'd5, 0, 1'b0);
    check("t2_count_one", 32'(count), 32'd1);
    drive_cycle(2'b01, 2'b00, 0, 0, 1'b0);
    check("t2_regrant", 32'(obs_lane0), 32'd5);

    // Same-cycle alloc and free with a single free entry.
    drive_cycle(2'b00, 2'b01, 6'd44, 0, 1'b0);
    check("t4_count_one", 32'(count), 32'd1);
    drive_cycle(2'b11, 2'b11, 6'd7, 6'd9, 1'b0);
    check("t4_ready", 32'(obs_ready), 32'd0);
    check("t4_count", 32'(count), 32'd3);
    drive_cycle(2'b11, 2'b00, 0, 0, 1'b0);
    check("t4_lane0", 32'(obs_lane0), 32'd44);
    check("t4_lane1", 32'(obs_lane1), 32'd7);

    // Flush rewinds to the retire head; tail - head_ret is always FL, so the list is full again.
    do_reset();
    for (int c = 0; c < 3; c++) drive_cycle(2'b11, 2'b00, 0, 0, 1'b0);
    drive_cycle(2'b00, 2'b11, 6'd40, 6'd41, 1'b0);
    drive_cycle(2'b11, 2'b00, 0, 0, 1'b1);
    check("t5_flush_ready", 32'(obs_ready), 32'd0);
    check("t5_count", 32'(count), 32'd32);
    drive_cycle(2'b11, 2'b00, 0, 0, 1'b0);
    check("t5_lane0", 32'(obs_lane0), 32'd34);
    check("t5_lane1", 32'(obs_lane1), 32'd35);

`ifdef FREE_LIST_CHECK_EN
    do_reset();
    drive_cycle(2'b00, 2'b01, 6'd50, 0, 1'b0);
    check("t6_err_set", 32'(fl_err), 32'd1);
    for (int c = 0; c < 3; c++) drive_cycle(2'b00, 2'b00, 0, 0, 1'b0);
    check("t6_err_sticky", 32'(fl_err), 32'd1);
    do_reset();
    check("t6_err_clear", 32'(fl_err), 32'd0);
`endif

    // Random legal traffic with occasional flushes and one mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      av = 2'($urandom_range(0, 3));
      fv = 2'($urandom_range(0, 3));
      room = inflight.size();
      if (popcnt2(fv) > room) fv = (room == 1) ? 2'b10 : 2'b00;
      drive_cycle(av, fv, PIDX'($urandom_range(ARF, PRF - 1)),
                  PIDX'($urandom_range(ARF, PRF - 1)), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
